// File: rtl/ahb3lite_cmd_master.sv
// ahb3lite_cmd_master
//   Single-outstanding AHB3-lite master. Takes one command at a time from a
//   valid/ready channel, issues it as a NONSEQ SINGLE transfer, and returns
//   read data / error status on a valid/ready response channel. Address and
//   data phases never overlap, so at most one transfer every 4 cycles.
//
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_write/size/addr/wdata   command fields (size in HSIZE encoding)
//   rsp_valid/ready     response handshake
//   rsp_rdata/rsp_err   read data (0 for writes/errors), error flag
//   busy                high while a command is in flight
//   H*                  AHB3-lite master port (HSEL/HBURST/HPROT/HMASTLOCK constant)
module ahb3lite_cmd_master #(
  parameter int         HADDR_SIZE = 32,
  parameter int         HDATA_SIZE = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic [HDATA_SIZE-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HWRITE,
  output logic                  HMASTLOCK,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HRESP,
  input  logic                  HREADY
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

  state_t                state, state_nxt;
  logic [HDATA_SIZE-1:0] wdata_q;
  logic                  accept, reject;

  assign HSEL      = 1'b1;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  // cmd_ready is high exactly while in IDLE, so it doubles as the state qualifier.
  assign accept = cmd_valid & cmd_ready;

  // Sizes above a word, or addresses not aligned to the transfer size, are
  // answered locally with an error and never reach the bus.
  assign reject = (cmd_size > 3'd2) ||
                  ((cmd_size == 3'd1) && cmd_addr[0]) ||
                  ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = reject ? ST_RESP : ST_ADDR;
      ST_ADDR: if (HREADY)    state_nxt = ST_DATA;
      ST_DATA: if (HREADY)    state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs. HTRANS drops to IDLE as soon as the address phase
  // completes, so the second ERROR cycle never sees a pending NONSEQ.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      HTRANS    <= TR_IDLE;
      HADDR     <= '0;
      HWDATA    <= '0;
      HSIZE     <= 3'd0;
      HWRITE    <= 1'b0;
      wdata_q   <= '0;
    end else begin
      cmd_ready <= (state_nxt == ST_IDLE);
      busy      <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            wdata_q <= cmd_wdata;
            if (reject) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              HTRANS <= TR_NONSEQ;
              HADDR  <= cmd_addr;
              HSIZE  <= cmd_size;
              HWRITE <= cmd_write;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            HTRANS <= TR_IDLE;
            if (HWRITE) HWDATA <= wdata_q;
          end
        end
        ST_DATA: begin
          // HRDATA is only captured on the completing edge; wait-state
          // garbage never reaches rsp_rdata.
          if (HREADY) begin
            rsp_valid <= 1'b1;
            rsp_err   <= HRESP;
            rsp_rdata <= (HRESP || HWRITE) ? '0 : HRDATA;
          end
        end
        ST_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
module tb_ahb3lite_cmd_master;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        HSEL, HWRITE, HMASTLOCK, HRESP, HREADY;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  ahb3lite_cmd_master dut (
    .CLK(CLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWRITE(HWRITE),
    .HMASTLOCK(HMASTLOCK), .HRDATA(HRDATA), .HRESP(HRESP), .HREADY(HREADY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Expected bus transfer, including the wait states the slave should insert.
  typedef struct {
    logic [31:0] a;
    logic [2:0]  sz;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] rdv;
    int          aw;
    int          dw;
    logic        unm;
    int          acc;
  } bus_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int nchk = 0;
  int nerr = 0;
  int rsp_mode = 0;   // 0: always ready, 1: random, 2: held low

  // slave / monitor state
  bus_t cur;
  logic ap_active = 1'b0, dp_active = 1'b0, err1 = 1'b0;
  int   acnt = 0, dcnt = 0;
  rsp_t ecur;
  logic holding = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Drive one command and record what the bus and response channel must show.
  task automatic issue(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int aw, input int dw,
                       input logic [31:0] rdv);
    int   n;
    logic rej, unm, err;
    rsp_t r;
    bus_t b;
    n = 0;
    @(negedge CLK);
    while (!cmd_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!cmd_ready) begin
      fail_now("cmd_ready_timeout");
      return;
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_size  = sz;
    cmd_addr  = a;
    cmd_wdata = wd;
    rej = (sz > 3'd2) || ((a % (32'd1 << sz)) != 0);
    unm = (a >= 32'hF000_0000);
    err = rej || unm;
    r.err   = err;
    r.rdata = (!err && !wr) ? rdv : 32'h0;
    r.due   = cyc + (rej ? 1 : 3 + aw + dw + (unm ? 1 : 0));
    rsp_q.push_back(r);
    if (!rej) begin
      b.a = a; b.sz = sz; b.wr = wr; b.wd = wd; b.rdv = rdv;
      b.aw = aw; b.dw = dw; b.unm = unm; b.acc = cyc;
      bus_q.push_back(b);
    end
    @(negedge CLK);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_size  = 3'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || holding) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (rsp_q.size() != 0 || holding) fail_now("drain_timeout");
  endtask

  // Slave model and bus checker: decides HREADY/HRESP/HRDATA for the current
  // cycle from the transfer the master is presenting.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET) begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
      end else begin
        case (rsp_mode)
          0:       rsp_ready = 1'b1;
          1:       rsp_ready = 1'($urandom);
          default: rsp_ready = 1'b0;
        endcase
        if (dp_active) begin
          chk("htrans_idle_in_data", 32'(HTRANS), 32'h0);
          if (cur.wr) chk("hwdata", HWDATA, cur.wd);
          HRDATA = $urandom;
          if (dcnt > 0) begin
            HREADY = 1'b0; HRESP = 1'b0; dcnt--;
          end else if (cur.unm && !err1) begin
            HREADY = 1'b0; HRESP = 1'b1; err1 = 1'b1;
          end else if (cur.unm) begin
            HREADY = 1'b1; HRESP = 1'b1; dp_active = 1'b0;
          end else begin
            HREADY = 1'b1; HRESP = 1'b0; dp_active = 1'b0;
            if (!cur.wr) HRDATA = cur.rdv;
          end
        end else if (ap_active || HTRANS == 2'b10) begin
          HRESP = 1'b0;
          if (!ap_active) begin
            if (bus_q.size() == 0) begin
              fail_now("unexpected_nonseq");
              HREADY = 1'b1;
            end else begin
              cur = bus_q.pop_front();
              ap_active = 1'b1;
              acnt = cur.aw;
              chk("nonseq_cycle", 32'(cyc), 32'(cur.acc + 1));
            end
          end
          if (ap_active) begin
            chk("htrans_nonseq", 32'(HTRANS), 32'h2);
            chk("haddr", HADDR, cur.a);
            chk("hsize", 32'(HSIZE), 32'(cur.sz));
            chk("hwrite", 32'(HWRITE), 32'(cur.wr));
            if (acnt > 0) begin
              HREADY = 1'b0; acnt--;
            end else begin
              HREADY = 1'b1; ap_active = 1'b0; dp_active = 1'b1;
              dcnt = cur.dw; err1 = 1'b0;
            end
          end
        end else begin
          HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard at the first cycle of each response.
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (!RESET && rsp_valid) begin
        chk("busy_during_rsp", 32'(busy), 32'h1);
        if (!holding) begin
          if (rsp_q.size() == 0) fail_now("unexpected_rsp");
          else begin
            ecur = rsp_q.pop_front();
            holding = 1'b1;
            chk("rsp_cycle", 32'(cyc), 32'(ecur.due));
            chk("rsp_err", 32'(rsp_err), 32'(ecur.err));
            chk("rsp_rdata", rsp_rdata, ecur.rdata);
          end
        end else begin
          chk("rsp_err_stable", 32'(rsp_err), 32'(ecur.err));
          chk("rsp_rdata_stable", rsp_rdata, ecur.rdata);
        end
        if (rsp_ready) holding = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  sz;
    logic [31:0] a;
    int          r, n;
    RESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 3'd0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0; rsp_ready = 1'b0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;

    repeat (2) @(negedge CLK);
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_hsize", 32'(HSIZE), 32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("hsel", 32'(HSEL), 32'h1);
    chk("hburst", 32'(HBURST), 32'h0);
    chk("hprot", 32'(HPROT), 32'h3);
    chk("hmastlock", 32'(HMASTLOCK), 32'h0);
    #2 RESET = 1'b0;

    // directed cases
    issue(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0);          drain();
    issue(1'b0, 3'd2, 32'h0000_0010, 32'h0, 0, 2, 32'hDEAD_BEEF);          drain();
    issue(1'b0, 3'd2, 32'h0000_0024, 32'h0, 3, 0, 32'hCAFE_F00D);          drain();
    issue(1'b1, 3'd1, 32'h0000_0032, 32'h1357_9BDF, 3, 1, 32'h0);          drain();
    issue(1'b0, 3'd2, 32'hF000_0000, 32'h0, 0, 0, 32'h1111_2222);          drain();
    issue(1'b1, 3'd0, 32'hF000_0003, 32'h55, 1, 2, 32'h0);                 drain();
    issue(1'b0, 3'd1, 32'h0000_0001, 32'h0, 0, 0, 32'h0);                  drain();
    issue(1'b0, 3'd3, 32'h0000_0000, 32'h0, 0, 0, 32'h0);                  drain();
    issue(1'b1, 3'd2, 32'h0000_0042, 32'h0, 0, 0, 32'h0);                  drain();

    // response back-pressure, then reset in the middle of an address phase
    rsp_mode = 2;
    issue(1'b0, 3'd2, 32'h0000_0040, 32'h0, 0, 0, 32'h1234_5678);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!rsp_valid) fail_now("rsp_valid_timeout");
    repeat (5) @(negedge CLK);
    rsp_mode = 0;
    drain();

    issue(1'b1, 3'd2, 32'h0000_0080, 32'hA5A5_5A5A, 6, 0, 32'h0);
    @(negedge CLK);
    #2;
    bus_q.delete(); rsp_q.delete();
    ap_active = 1'b0; dp_active = 1'b0; holding = 1'b0;
    RESET = 1'b1;
    #1;
    chk("arst_htrans", 32'(HTRANS), 32'h0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("arst_haddr", HADDR, 32'h0);
    @(negedge CLK);
    #2 RESET = 1'b0;
    repeat (6) @(negedge CLK);
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 9);
      sz = (r == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
      a  = $urandom & 32'h0000_FFFF;
      if (r < 7 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      if (r == 9) a[31:28] = 4'hF;
      rsp_mode = $urandom_range(0, 1);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      issue(1'($urandom), sz, a, $urandom, $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom);
    end
    rsp_mode = 0;
    drain();
    repeat (4) @(negedge CLK);
    if (bus_q.size() != 0) fail_now("bus_queue_not_empty");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
